// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

    localparam int BOOTH_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } booth_state_t;

    // Wide enough to hold the iteration count in both signed and unsigned builds.
    function automatic int count_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/sub of M, then an
// arithmetic right shift of {acc, q, q_m1}.
module booth_step #(
    parameter int AW = 9,
    parameter int QW = 8
) (
    input  logic [AW-1:0] acc_i,
    input  logic [QW-1:0] q_i,
    input  logic          q_m1_i,
    input  logic [AW-1:0] m_i,
    output logic [AW-1:0] acc_o,
    output logic [QW-1:0] q_o,
    output logic          q_m1_o
);

    logic [AW-1:0] sum;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sum = acc_i;
        case ({q_i[0], q_m1_i})
            2'b01:   sum = acc_i + m_i;
            2'b10:   sum = acc_i - m_i;
            default: sum = acc_i;
        endcase
    end

    assign acc_o  = {sum[AW-1], sum[AW-1:1]};
    assign q_o    = {sum[0], q_i[QW-1:1]};
    assign q_m1_o = q_i[0];

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier with fixed latency and a one-cycle done pulse.
// Define BOOTH_UNSIGNED_EN to treat A and B as unsigned (one extra iteration).
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] Y,
    output logic               busy,
    output logic               done
);

    localparam int CW = count_width(WIDTH);
    localparam int YW = 2 * WIDTH;

`ifdef BOOTH_UNSIGNED_EN
    localparam int AW = WIDTH + 2;
    localparam int QW = WIDTH + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH + 1);
`else
    localparam int AW = WIDTH + 1;
    localparam int QW = WIDTH;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
`endif
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    booth_state_t  state_q, state_d;
    logic [AW-1:0] acc_q, acc_d, m_q, m_d, acc_n, m_init;
    logic [QW-1:0] q_q, q_d, q_n, q_init;
    logic          q_m1_q, q_m1_d, q_m1_n;
    logic [CW-1:0] count_q, count_d;
    logic [YW-1:0] y_q, y_d;

`ifdef BOOTH_UNSIGNED_EN
    assign m_init = {2'b00, A};
    assign q_init = {1'b0, B};
`else
    assign m_init = {A[WIDTH-1], A};
    assign q_init = B;
`endif

    booth_step #(
        .AW (AW),
        .QW (QW)
    ) u_step (
        .acc_i  (acc_q),
        .q_i    (q_q),
        .q_m1_i (q_m1_q),
        .m_i    (m_q),
        .acc_o  (acc_n),
        .q_o    (q_n),
        .q_m1_o (q_m1_n)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        m_d     = m_q;
        q_d     = q_q;
        q_m1_d  = q_m1_q;
        count_d = count_q;
        y_d     = y_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = m_init;
                    q_d     = q_init;
                    acc_d   = '0;
                    q_m1_d  = 1'b0;
                    count_d = CNT_LOAD;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy    = 1'b1;
                acc_d   = acc_n;
                q_d     = q_n;
                q_m1_d  = q_m1_n;
                count_d = count_q - CNT_ONE;
                // The last step's shifted result is captured directly, not one cycle later.
                if (count_q == CNT_ONE) begin
                    y_d     = YW'({acc_n, q_n});
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q_m1_q  <= 1'b0;
            count_q <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q_m1_q  <= q_m1_d;
            count_q <= count_d;
            y_q     <= y_d;
        end
    end

    assign Y = y_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed self-checking bench for booth_seq_multiplier (signed build by default,
// unsigned vectors when BOOTH_UNSIGNED_EN is defined).
module tb_booth_seq_multiplier;

    localparam int WIDTH = 8;
`ifdef BOOTH_UNSIGNED_EN
    localparam int LAT = WIDTH + 1;
`else
    localparam int LAT = WIDTH;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2*WIDTH-1:0] Y;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;

    booth_seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Y     (Y),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Launches one operation from IDLE and reports what was observed; no checking here.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] y, output int lat,
                         output logic busy_at_done, output logic busy_after,
                         output logic done_after);
        lat = -1;
        y = 'x;
        busy_at_done = 1'bx;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= LAT + 10; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                y = Y;
                busy_at_done = busy;
                break;
            end
        end
        @(posedge clk);
        @(negedge clk);
        busy_after = busy;
        done_after = done;
    endtask

    task automatic op_checked(input string name, input logic [7:0] a, input logic [7:0] b,
                              input logic [15:0] exp_y);
        logic [15:0] y;
        int          lat;
        logic        bd, ba, da;
        do_op(a, b, y, lat, bd, ba, da);
        checks++;
        if (y !== exp_y) begin
            errors++;
            $display("FAIL %s product: got %h expected %h", name, y, exp_y);
        end
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b1;
        A = 8'd3;
        B = 8'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (Y !== 16'h0000) begin
            errors++;
            $display("FAIL reset Y: got %h expected 0000", Y);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset busy: got %b expected 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset done: got %b expected 0", done);
        end
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [15:0] y;
        int          lat;
        logic        bd, ba, da;
        do_op(8'd3, 8'd5, y, lat, bd, ba, da);
        checks++;
        if (y !== 16'h000F) begin
            errors++;
            $display("FAIL basic 3*5 product: got %h expected 000f", y);
        end
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL basic latency: got %0d expected %0d", lat, LAT);
        end
        checks++;
        if (bd !== 1'b1) begin
            errors++;
            $display("FAIL basic busy at done: got %b expected 1", bd);
        end
        checks++;
        if (ba !== 1'b0) begin
            errors++;
            $display("FAIL basic busy after done: got %b expected 0", ba);
        end
        checks++;
        if (da !== 1'b0) begin
            errors++;
            $display("FAIL basic done width: got %b expected 0", da);
        end
    endtask

    task automatic test_signed();
        op_checked("neg3*5", 8'hFD, 8'd5, 16'hFFF1);
        op_checked("neg128*127", 8'h80, 8'h7F, 16'hC080);
        op_checked("neg128*neg128", 8'h80, 8'h80, 16'h4000);
        op_checked("neg1*neg1", 8'hFF, 8'hFF, 16'h0001);
    endtask

    task automatic test_unsigned();
        op_checked("u200*200", 8'd200, 8'd200, 16'h9C40);
        op_checked("u255*255", 8'd255, 8'd255, 16'hFE01);
    endtask

    task automatic test_zero();
        op_checked("0*5a", 8'h00, 8'h5A, 16'h0000);
    endtask

    task automatic test_ignore_start();
        int          done_cnt = 0;
        int          lat = -1;
        logic [15:0] yv = 'x;
        @(negedge clk);
        A = 8'd7;
        B = 8'd9;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= LAT + 6; n++) begin
            if (n == 2) begin
                start = 1'b1;
                A = 8'd2;
                B = 8'd2;
            end else if (n == 3) begin
                start = 1'b0;
                A = 8'h55;
                B = 8'h33;
            end
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = n;
                    yv = Y;
                end
            end
        end
        checks++;
        if (yv !== 16'h003F) begin
            errors++;
            $display("FAIL ignore_start product: got %h expected 003f", yv);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL ignore_start done count: got %0d expected 1", done_cnt);
        end
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL ignore_start latency: got %0d expected %0d", lat, LAT);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start idle afterwards: busy %b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int d1 = -1;
        int d2 = -1;
        @(negedge clk);
        A = 8'd3;
        B = 8'd5;
        start = 1'b1;
        for (int n = 1; n <= 4 * LAT + 10; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                if (d1 < 0) begin
                    d1 = n;
                end else begin
                    d2 = n;
                    break;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (d1 !== LAT + 1) begin
            errors++;
            $display("FAIL back_to_back first done: got %0d expected %0d", d1, LAT + 1);
        end
        checks++;
        if ((d2 - d1) !== LAT + 2) begin
            errors++;
            $display("FAIL back_to_back spacing: got %0d expected %0d", d2 - d1, LAT + 2);
        end
        checks++;
        if (Y !== 16'h000F) begin
            errors++;
            $display("FAIL back_to_back product: got %h expected 000f", Y);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back idle after release: busy %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        A = 8'd100;
        B = 8'd100;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (Y !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid Y: got %h expected 0000", Y);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid busy: got %b expected 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid done: got %b expected 0", done);
        end
        @(negedge clk);
        rst = 1'b1;
        op_checked("after_reset 6*6", 8'd6, 8'd6, 16'h0024);
    endtask

    initial begin
        start = 1'b0;
        A = '0;
        B = '0;
        rst = 1'b0;
        test_reset();
        test_basic();
`ifdef BOOTH_UNSIGNED_EN
        test_unsigned();
`else
        test_signed();
`endif
        test_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
